booth_controller: RTL and testbench

- Moore FSM that sequences the radix-2 Booth multiplier datapath: operand load, per-iteration add/subtract/shift, and iteration count via the 5-bit partial-product counter.
- Accepts multiply requests with a valid/ready handshake and signals completion with a valid/ready handshake.
- Sits between the issuing logic and the datapath (accumulator/multiplier shift register plus counter). Drives only control strobes; carries no operand data.

---
 rtl/booth_controller.sv | 98 +++++++++
 tb/tb_booth_controller.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/booth_controller.sv
// Moore control FSM for a radix-2 Booth multiplier datapath (load, add/sub, shift, count).
// Optional macro BOOTH_SKIP_SHIFT_EN folds the shift into CHECK for 00/11 bit pairs.
module booth_controller #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic [1:0]       booth_bits,
  input  logic [CNT_W-1:0] count,
  output logic             ld_operands,
  output logic             cnt_start,
  output logic             en_add,
  output logic             en_sub,
  output logic             en_shift,
  output logic             en_PP,
  output logic             busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t state, state_nxt;
  logic   last_iter;

  // count is the pre-increment value, so LAST marks the final iteration
  assign last_iter = (count == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    ld_operands = 1'b0;
    cnt_start   = 1'b0;
    en_add      = 1'b0;
    en_sub      = 1'b0;
    en_shift    = 1'b0;
    en_PP       = 1'b0;
    busy        = 1'b1;
    case (state)
      IDLE: begin
        busy     = 1'b0;
        // held low during reset even though the state already reads IDLE
        in_ready = !reset;
        if (in_valid && !reset) state_nxt = LOAD;
      end
      LOAD: begin
        ld_operands = 1'b1;
        cnt_start   = 1'b1;
        state_nxt   = CHECK;
      end
      CHECK: begin
        state_nxt = SHIFT;
        case (booth_bits)
          2'b01: en_add = 1'b1;
          2'b10: en_sub = 1'b1;
          default: begin
`ifdef BOOTH_SKIP_SHIFT_EN
            en_shift  = 1'b1;
            en_PP     = 1'b1;
            state_nxt = last_iter ? DONE : CHECK;
`endif
          end
        endcase
      end
      SHIFT: begin
        en_shift  = 1'b1;
        en_PP     = 1'b1;
        state_nxt = last_iter ? DONE : CHECK;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_booth_controller.sv
// Directed bench for booth_controller with a behavioural model of the iteration counter.
module tb_booth_controller;

  localparam int WIDTH = 16;
  localparam int CNT_W = 5;
`ifdef BOOTH_SKIP_SHIFT_EN
  localparam int LAT_SKIP = 18;
`else
  localparam int LAT_SKIP = 34;
`endif

  logic             clk, reset, in_valid, in_ready, out_valid, out_ready;
  logic [1:0]       booth_bits;
  logic [CNT_W-1:0] cnt;
  logic             ld_operands, cnt_start, en_add, en_sub, en_shift, en_PP, busy;

  logic       alt;
  logic [1:0] fix_bb;

  int checks = 0;
  int errors = 0;
  int na, ns, nsh, npp, nld, nboth, nbad, lat;

  booth_controller #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .booth_bits(booth_bits),
    .count(cnt), .ld_operands(ld_operands), .cnt_start(cnt_start),
    .en_add(en_add), .en_sub(en_sub), .en_shift(en_shift), .en_PP(en_PP),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // iteration counter the controller drives
  always_ff @(posedge clk) begin
    if (cnt_start)  cnt <= '0;
    else if (en_PP) cnt <= cnt + 1'b1;
  end

  // alternating pattern: even iterations 10 (sub), odd iterations 01 (add)
  assign booth_bits = alt ? (cnt[0] ? 2'b01 : 2'b10) : fix_bb;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int outs_vec();
    return {23'd0, in_ready, out_valid, ld_operands, cnt_start, en_add, en_sub,
            en_shift, en_PP, busy};
  endfunction

  // Accepts a request from IDLE and counts strobes until out_valid (left in DONE)
  task automatic run_mult(input logic noisy, input logic use_alt);
    int n;
    na = 0; ns = 0; nsh = 0; npp = 0; nld = 0; nboth = 0; nbad = 0; lat = -1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    @(posedge clk);
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      na  += int'(en_add);
      ns  += int'(en_sub);
      nsh += int'(en_shift);
      npp += int'(en_PP);
      nld += int'(ld_operands);
      if (en_add && en_sub) nboth++;
      if (use_alt && ((en_sub && cnt[0]) || (en_add && !cnt[0]))) nbad++;
      if (out_valid) begin
        lat = n;
        in_valid = 1'b0;
        break;
      end
      in_valid = noisy ? logic'(n[0]) : 1'b0;
    end
    if (lat < 0) chk("done_timeout", 0, 1);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clk);
    chk("hs_idle_ready", int'(in_ready), 1);
    chk("hs_out_valid_low", int'(out_valid), 0);
    out_ready = 1'b0;
  endtask

  typedef struct {
    string      name;
    logic       alt;
    logic [1:0] bb;
    logic       noisy;
    int         nadd;
    int         nsub;
    int         lat;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{"hold01", 1'b0, 2'b01, 1'b0, 16, 0, 34};
    vecs[1] = '{"alt10_01", 1'b1, 2'b00, 1'b0, 8, 8, 34};
    vecs[2] = '{"hold00", 1'b0, 2'b00, 1'b0, 0, 0, LAT_SKIP};
    vecs[3] = '{"hold11", 1'b0, 2'b11, 1'b0, 0, 0, LAT_SKIP};
    vecs[4] = '{"hold10", 1'b0, 2'b10, 1'b0, 0, 16, 34};
    vecs[5] = '{"noisy_in", 1'b0, 2'b01, 1'b1, 16, 0, 34};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; alt = 1'b0; fix_bb = 2'b00;
    #1;
    chk("reset_outs_zero", outs_vec(), 0);
    @(negedge clk);
    chk("reset_hold_zero", outs_vec(), 0);
    reset = 1'b0;
    #1;
    chk("post_reset_in_ready", int'(in_ready), 1);
    chk("post_reset_busy", int'(busy), 0);

    foreach (vecs[i]) begin
      alt = vecs[i].alt; fix_bb = vecs[i].bb;
      @(negedge clk);
      run_mult(vecs[i].noisy, vecs[i].alt);
      chk({vecs[i].name, "_add"}, na, vecs[i].nadd);
      chk({vecs[i].name, "_sub"}, ns, vecs[i].nsub);
      chk({vecs[i].name, "_shift"}, nsh, WIDTH);
      chk({vecs[i].name, "_pp"}, npp, WIDTH);
      chk({vecs[i].name, "_ld"}, nld, 1);
      chk({vecs[i].name, "_both"}, nboth, 0);
      chk({vecs[i].name, "_parity"}, nbad, 0);
      chk({vecs[i].name, "_latency"}, lat, vecs[i].lat);
      handshake();
    end

    // backpressure in DONE
    alt = 1'b0; fix_bb = 2'b01;
    @(negedge clk);
    run_mult(1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_busy", int'(busy), 1);
    end
    handshake();

    // in_valid held through the DONE handshake: one LOAD, two cycles later
    @(negedge clk);
    run_mult(1'b0, 1'b0);
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("held_idle_first", int'(in_ready), 1);
    chk("held_no_early_ld", int'(ld_operands), 0);
    out_ready = 1'b0;
    @(negedge clk);
    chk("held_load", int'(ld_operands), 1);
    chk("held_in_ready_low", int'(in_ready), 0);
    in_valid = 1'b0;
    nld = 0; lat = -1;
    for (int n = 2; n < 200; n++) begin
      @(negedge clk);
      nld += int'(ld_operands);
      if (out_valid) begin lat = n; break; end
    end
    chk("held_extra_ld", nld, 0);
    chk("held_latency", lat, 34);
    handshake();

    // reset asserted in SHIFT of iteration 7 (8th en_shift pulse)
    fix_bb = 2'b01;
    @(negedge clk);
    in_valid = 1'b1;
    @(posedge clk);
    nsh = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      in_valid = 1'b0;
      nsh += int'(en_shift);
      if (nsh == 8) break;
    end
    chk("rst_reached_iter7", nsh, 8);
    chk("rst_iter7_count", int'(cnt), 7);
    reset = 1'b1;
    #1;
    chk("rst_mid_outs_zero", outs_vec(), 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_mid_in_ready", int'(in_ready), 1);
    chk("rst_mid_busy", int'(busy), 0);
    @(negedge clk);
    chk("rst_stays_idle", int'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
